// File: rtl/cfg_pkg.sv
// Shared types and default sizing for the slice configuration chain loader.
// Chain length is derived from the slice geometry so a single edit here keeps the loader in step with the fabric.
// Also holds the FSM state encoding and a small ceiling-divide helper.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Slice geometry: each LUT carries S_XX_BASE entries of four config bits.
  localparam int S_XX_BASE = 17;
  localparam int NUM_LUTS  = 2;
  localparam int MUX_LVLS  = 2;
  localparam int LUT_BITS  = NUM_LUTS * S_XX_BASE * 4;

  // LUT bits, one select bit per mux level, then the use_cc bit.
  localparam int CHAIN_LEN_DEF = LUT_BITS + MUX_LVLS + 1;
  localparam int WORD_W_DEF    = 32;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Host-side word stream into the chain loader: start strobe plus a valid/ready word channel.
// No storage; purely a signal bundle.
// word_ready is driven by the loader from registered state only.
interface cfg_chain_loader_if #(
  parameter int WORD_W = 32
);

  logic              start;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output start,
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  start,
    input  word_in,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/cfg_serializer.sv
// MSB-first parallel-to-serial shifter with a count of bits still owed to the chain.
// Latency: a loaded word presents its MSB on msb_o the cycle after load_i.
// No backpressure of its own; the caller reloads when empty_o, or when last_o and shifting.
module cfg_serializer #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_dat_i,
  input  logic [CNT_W-1:0]  load_cnt_i,
  input  logic              shift_i,
  output logic              msb_o,
  output logic              empty_o,
  output logic              last_o
);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Load wins over shift: a reload only happens when the final owed bit goes out this cycle.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = load_dat_i;
      cnt_d = load_cnt_i;
    end else if (shift_i && (cnt_q != '0)) begin
      sh_d  = {sh_q[WORD_W-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Shift register and bit count state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_o   = sh_q[WORD_W-1];
  assign empty_o = (cnt_q == '0);
  assign last_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cfg_chain_loader.sv
// Serializes host config words MSB-first onto the slice chain, raising cen for exactly CHAIN_LEN cycles.
// Latency: start -> word_ready next cycle; an accepted word's MSB reaches cfg_out the cycle after acceptance.
// Backpressure: word_ready comes from registered state only; host stalls insert cen=0 gaps, never lose bits.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic               cclk,
  input  logic               rst,
  cfg_chain_loader_if.slave  host,
  output logic               cen,
  output logic               cfg_out,
  output logic               busy,
  output logic               done
);

  localparam int NWORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int BL_W   = $clog2(CHAIN_LEN + 1);
  localparam int WL_W   = $clog2(NWORDS + 1);
  localparam int SC_W   = $clog2(WORD_W + 1);

  state_e           state_q, state_d;
  logic [BL_W-1:0]  bits_left_q, bits_left_d;
  logic [WL_W-1:0]  words_left_q, words_left_d;

  logic             sh_msb;
  logic             sh_empty;
  logic             sh_last;
  logic             shifting;
  logic             accept;
  logic [BL_W-1:0]  bits_after;
  logic [SC_W-1:0]  load_cnt;

  // A bit leaves only while loading and the serializer still owes bits.
  assign shifting = (state_q == SHIFT) && !sh_empty;

  // Ready when the serializer is empty or emptying this cycle, so held-valid traffic has no bubbles.
  assign host.word_ready = (state_q == SHIFT) && (words_left_q != '0) &&
                           (sh_empty || (sh_last && shifting));
  assign accept          = host.word_valid && host.word_ready;

  // Bits still owed after this cycle's shift; the final word is trimmed to this so its tail is dropped.
  assign bits_after = bits_left_q - BL_W'(shifting);
  assign load_cnt   = (32'(bits_after) >= WORD_W) ? SC_W'(WORD_W) : SC_W'(bits_after);

  cfg_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (SC_W)
  ) u_ser (
    .clk_i      (cclk),
    .rst_i      (rst),
    .load_i     (accept),
    .load_dat_i (host.word_in),
    .load_cnt_i (load_cnt),
    .shift_i    (shifting),
    .msb_o      (sh_msb),
    .empty_o    (sh_empty),
    .last_o     (sh_last)
  );

  // Next-state and counter updates; start is only honoured outside SHIFT.
  always_comb begin
    state_d      = state_q;
    bits_left_d  = bits_left_q;
    words_left_d = words_left_q;
    case (state_q)
      IDLE, DONE: begin
        if (host.start) begin
          state_d      = SHIFT;
          bits_left_d  = BL_W'(CHAIN_LEN);
          words_left_d = WL_W'(NWORDS);
        end
      end
      SHIFT: begin
        if (accept) begin
          words_left_d = words_left_q - WL_W'(1);
        end
        if (shifting) begin
          bits_left_d = bits_after;
          if (bits_left_q == BL_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and load counters.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bits_left_q  <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      words_left_q <= words_left_d;
    end
  end

  assign cen     = shifting;
  assign cfg_out = shifting && sh_msb;
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_cfg_chain_loader.sv
`timescale 1ns/1ps
module tb_cfg_chain_loader;

  localparam int WW  = 32;
  localparam int CL  = 139;
  localparam int CL2 = 32;

  logic cclk = 1'b0;
  logic rst;
  always #5 cclk = ~cclk;

  cfg_chain_loader_if #(.WORD_W(WW)) h  ();
  cfg_chain_loader_if #(.WORD_W(WW)) h2 ();

  logic cen, cfg_out, busy, done;
  logic cen2, cfg_out2, busy2, done2;

  cfg_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .cclk(cclk), .rst(rst), .host(h),
    .cen(cen), .cfg_out(cfg_out), .busy(busy), .done(done)
  );

  cfg_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL2)) dut2 (
    .cclk(cclk), .rst(rst), .host(h2),
    .cen(cen2), .cfg_out(cfg_out2), .busy(busy2), .done(done2)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int c0     = 0;
  int exp_rem;
  int cen_cnt, first_cen, last_cen;
  bit abort_host = 1'b0;
  bit mon_en     = 1'b0;
  bit exp_q[$];
  bit exp2_q[$];
  bit exp_b;
  logic [WW-1:0] words [5];

  always @(posedge cclk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard push: the bits of a word the chain should actually receive.
  task automatic push_word(input logic [WW-1:0] w);
    int nb;
    nb = (exp_rem < WW) ? exp_rem : WW;
    for (int b = 0; b < nb; b++) exp_q.push_back(w[WW-1-b]);
    exp_rem -= nb;
  endtask

  task automatic host_send(input logic [WW-1:0] w);
    bit ok;
    ok = 1'b0;
    h.word_in    = w;
    h.word_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge cclk);
      if (abort_host || h.word_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge cclk); #1;
    h.word_valid = 1'b0;
    chk("word_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_all(input int gap_before, input int gap_len);
    for (int k = 0; k < 5; k++) begin
      if (abort_host) break;
      push_word(words[k]);
      if (k == gap_before) begin
        for (int t = 0; t < 300; t++) begin
          @(negedge cclk);
          if (h.word_ready || abort_host) break;
        end
        repeat (gap_len) begin @(posedge cclk); #1; end
      end
      host_send(words[k]);
    end
  endtask

  task automatic start_load();
    @(posedge cclk); #1;
    c0 = cyc;
    exp_rem = CL;
    exp_q.delete();
    cen_cnt = 0; first_cen = -1; last_cen = -1;
    h.start = 1'b1;
    @(posedge cclk); #1;
    h.start = 1'b0;
    chk("busy_c1", 32'(busy), 32'd1);
    chk("ready_c1", 32'(h.word_ready), 32'd1);
    chk("done_c1", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input int gaps);
    int seen;
    seen = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge cclk);
      if (done) begin
        seen = cyc - c0;
        break;
      end
    end
    chk("done_cycle", 32'(seen), 32'(CL + 2 + gaps));
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("ready_after_done", 32'(h.word_ready), 32'd0);
    chk("cen_count", 32'(cen_cnt), 32'(CL));
    chk("first_cen", 32'(first_cen), 32'd2);
    chk("cen_span", 32'(last_cen - first_cen + 1), 32'(CL + gaps));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Chain-side monitor for the main loader: pop and compare each shifted bit.
  always @(negedge cclk) begin
    if (mon_en && !rst && cen) begin
      cen_cnt++;
      if (first_cen < 0) first_cen = cyc - c0;
      last_cen = cyc - c0;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        chk("cfg_bit", 32'(cfg_out), 32'(exp_b));
      end
    end else if (mon_en && !rst && busy) begin
      chk("stall_cfg_zero", 32'(cfg_out), 32'd0);
    end
  end

  initial begin
    int acc, n2, seen2, first2;
    logic [WW-1:0] w2;
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h0123_4567;
    words[2] = 32'h89AB_CDEF;
    words[3] = 32'hFFFF_FFFF;
    words[4] = 32'hA5A5_A5A5;
    rst = 1'b1;
    h.start = 1'b0;  h.word_valid = 1'b0;  h.word_in = '0;
    h2.start = 1'b0; h2.word_valid = 1'b0; h2.word_in = '0;
    #12;
    chk("rst_cen", 32'(cen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(h.word_ready), 32'd0);
    chk("rst_cfg_out", 32'(cfg_out), 32'd0);
    @(negedge cclk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Full load, valid held high.
    start_load();
    send_all(-1, 0);
    wait_done(0);

    // Word offered after completion must never be taken.
    acc = 0;
    h.word_in = 32'h1234_5678;
    h.word_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge cclk);
      if (h.word_ready) acc++;
    end
    @(posedge cclk); #1;
    h.word_valid = 1'b0;
    chk("late_word_taken", 32'(acc), 32'd0);
    chk("done_sticky", 32'(done), 32'd1);

    // Restart from DONE with a 3-cycle host stall before word 3.
    start_load();
    send_all(2, 3);
    wait_done(3);

    // Start pulsed mid-load is ignored.
    start_load();
    fork
      send_all(-1, 0);
      begin
        while (cyc - c0 < 50) begin @(posedge cclk); #1; end
        h.start = 1'b1;
        @(posedge cclk); #1;
        h.start = 1'b0;
        chk("busy_after_restart_pulse", 32'(busy), 32'd1);
      end
    join
    wait_done(0);

    // Reset mid-load, then a fresh full load.
    start_load();
    fork
      send_all(-1, 0);
      begin
        while (cyc - c0 < 70) begin @(posedge cclk); #1; end
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        abort_host = 1'b1;
        #1;
        chk("midrst_cen", 32'(cen), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(h.word_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
      end
    join
    h.word_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge cclk);
    #1;
    rst = 1'b0;
    abort_host = 1'b0;
    start_load();
    send_all(-1, 0);
    wait_done(0);

    // Single-word chain: one accept, exact bit pattern, done at cycle 34.
    @(posedge cclk); #1;
    c0 = cyc;
    h2.start = 1'b1;
    @(posedge cclk); #1;
    h2.start = 1'b0;
    chk("s_ready_c1", 32'(h2.word_ready), 32'd1);
    w2 = 32'h8000_0001;
    exp2_q.delete();
    for (int b = 0; b < WW; b++) exp2_q.push_back(w2[WW-1-b]);
    h2.word_in = w2;
    h2.word_valid = 1'b1;
    acc = 0; n2 = 0; seen2 = -1; first2 = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge cclk);
      if (h2.word_valid && h2.word_ready) acc++;
      if (cen2) begin
        n2++;
        if (first2 < 0) first2 = cyc - c0;
        chk("s_sb_nonempty", 32'(exp2_q.size() != 0), 32'd1);
        if (exp2_q.size() != 0) begin
          exp_b = exp2_q.pop_front();
          chk("s_cfg_bit", 32'(cfg_out2), 32'(exp_b));
        end
      end
      if (done2 && seen2 < 0) seen2 = cyc - c0;
      if (t == 3) h2.word_in = 32'hFFFF_FFFF;
    end
    h2.word_valid = 1'b0;
    chk("s_accepts", 32'(acc), 32'd1);
    chk("s_cen_count", 32'(n2), 32'd32);
    chk("s_first_cen", 32'(first2), 32'd2);
    chk("s_done_cycle", 32'(seen2), 32'd34);
    chk("s_sb_drained", 32'(exp2_q.size()), 32'd0);
    chk("s_ready_after", 32'(h2.word_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
